add_sub_arbiter: RTL

//   Shares one ADD_SUB datapath instance between NUM_REQ requesters.
//   - Round-robin arbitration of incoming operations.
//   - Sequences the datapath's 1-cycle registered latency.
//   - Returns each result to its requester over a valid/ready response handshake.
//   - Sits between the requester agents and ADD_SUB (dp_* ports wire to a0/b0/doAdd0/result0).

---
 rtl/add_sub_pkg.sv | 14 +
 rtl/add_sub_arbiter_rr_arbiter.sv | 35 +++
 rtl/add_sub_arbiter.sv | 106 ++++++++++
 3 files changed

// File: rtl/add_sub_pkg.sv
// Shared types and defaults for the ADD_SUB arbiter slice (no logic, no latency).
// FSM state encoding, default operand width and a wrap-around increment helper.
package add_sub_pkg;

  typedef enum logic [1:0] {IDLE, EXEC, CAPT, RESP} state_t;

  localparam int DATA_W_DEF = 8;
  localparam int RES_W_DEF  = DATA_W_DEF + 1;

  function automatic int wrap_inc(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/add_sub_arbiter_rr_arbiter.sv
// Round-robin pick starting at ptr; purely combinational, zero latency.
// No backpressure of its own: the parent gates req and owns ptr.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx
);

  logic             w_found;
  logic [IDX_W-1:0] w_idx;
  int               w_j;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    w_found = 1'b0;
    w_idx   = '0;
    w_j     = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_j = int'(ptr) + i;
      if (w_j >= NUM_REQ) w_j = w_j - NUM_REQ;
      w_idx = IDX_W'(w_j);
      if (!w_found && req[w_idx]) begin
        w_found    = 1'b1;
        gnt[w_idx] = 1'b1;
        gnt_idx    = w_idx;
      end
    end
  end

endmodule

// File: rtl/add_sub_arbiter.sv
// Shares one registered ADD_SUB among NUM_REQ requesters; accept-to-rsp_valid 3 cycles.
// One op in flight: req_ready only in IDLE, response held until rsp_ready of its owner.
module add_sub_arbiter
  import add_sub_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  input  logic [NUM_REQ-1:0]        req_do_add,
  output logic [DATA_W-1:0]         dp_a,
  output logic [DATA_W-1:0]         dp_b,
  output logic                      dp_do_add,
  input  logic [DATA_W:0]           dp_result,
  output logic [NUM_REQ-1:0]        rsp_valid,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic [DATA_W:0]           rsp_result,
  output logic                      busy,
  output logic [CNT_W-1:0]          ops_done
);

  localparam int RES_W = DATA_W + 1;
  localparam int IDX_W = $clog2(NUM_REQ);

  state_t             r_state, w_next_state;
  logic [IDX_W-1:0]   r_ptr, r_gidx, w_gnt_idx;
  logic [NUM_REQ-1:0] w_arb_req, w_gnt;
  logic               w_accept, w_rsp_done;
  logic [DATA_W-1:0]  r_dp_a, r_dp_b;
  logic               r_dp_do_add;
  logic [RES_W-1:0]   r_rsp_result;
  logic [CNT_W-1:0]   r_ops_done;

  // Requests are only visible to the arbiter in IDLE, so late arrivals wait a full turn.
  assign w_arb_req  = (r_state == IDLE) ? req_valid : '0;
  assign w_accept   = |w_arb_req;
  assign w_rsp_done = (r_state == RESP) && rsp_ready[r_gidx];

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
    .req     (w_arb_req),
    .ptr     (r_ptr),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    req_ready    = '0;
    rsp_valid    = '0;
    busy         = (r_state != IDLE);
    case (r_state)
      IDLE: begin
        req_ready = w_gnt;
        if (w_accept) w_next_state = EXEC;
      end
      EXEC: w_next_state = CAPT;
      CAPT: w_next_state = RESP;
      RESP: begin
        rsp_valid[r_gidx] = 1'b1;
        if (w_rsp_done) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr        <= '0;
      r_gidx       <= '0;
      r_dp_a       <= '0;
      r_dp_b       <= '0;
      r_dp_do_add  <= 1'b0;
      r_rsp_result <= '0;
      r_ops_done   <= '0;
    end else begin
      if (w_accept) begin
        r_ptr       <= IDX_W'(wrap_inc(int'(w_gnt_idx), NUM_REQ));
        r_gidx      <= w_gnt_idx;
        r_dp_a      <= req_a[w_gnt_idx*DATA_W +: DATA_W];
        r_dp_b      <= req_b[w_gnt_idx*DATA_W +: DATA_W];
        r_dp_do_add <= req_do_add[w_gnt_idx];
      end
      if (r_state == CAPT) r_rsp_result <= dp_result;
      // Counter sticks at all-ones rather than wrapping.
      if (w_rsp_done && (r_ops_done != '1)) r_ops_done <= r_ops_done + CNT_W'(1);
    end
  end

  assign dp_a       = r_dp_a;
  assign dp_b       = r_dp_b;
  assign dp_do_add  = r_dp_do_add;
  assign rsp_result = r_rsp_result;
  assign ops_done   = r_ops_done;

endmodule
